// File: rtl/rom_ctrl_pkg.sv
// Shared types for the ROM-checker hash feeder: FSM state encoding and the
// KMAC application request bundle.
package rom_ctrl_pkg;

  typedef enum logic [4:0] {
    StHash  = 5'b00001,
    StFlush = 5'b00010,
    StTop   = 5'b00100,
    StDone  = 5'b01000,
    StError = 5'b10000
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } kmac_req_t;

  // Byte strobe covering the low ceil(dw/8) bytes of a message word.
  function automatic logic [7:0] strb_mask(input int unsigned dw);
    logic [7:0] m;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i] = (i < (dw + 7) / 8);
    end
    return m;
  endfunction

endpackage

// File: rtl/rom_ctrl_hash_feeder_oreg.sv
// Single-entry KMAC output register: holds its word until the KMAC handshake,
// can be reloaded in the handshake cycle, and can be flushed (dropping the word).
module rom_ctrl_hash_feeder_oreg
  import rom_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_strb,
  input  logic        i_last,
  input  logic        i_ready,
  output kmac_req_t   o_req,
  output logic        o_can_load
);

  kmac_req_t r_req;

  assign o_req      = r_req;
  assign o_can_load = !r_req.valid || i_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req <= '0;
    end else if (i_flush) begin
      r_req.valid <= 1'b0;
    end else if (i_load) begin
      r_req.valid <= 1'b1;
      r_req.data  <= i_data;
      r_req.strb  <= i_strb;
      r_req.last  <= i_last;
    end else if (r_req.valid && i_ready) begin
      r_req.valid <= 1'b0;
    end
  end

  // A pending word may only disappear through a handshake or a flush.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (r_req.valid && !i_ready && !i_flush) |=> r_req.valid);

endmodule

// File: rtl/rom_ctrl_hash_feeder.sv
// Consumer of the ROM-checker read stream: forwards non-top words to KMAC,
// captures the top words as the expected digest and flags out-of-order input.
module rom_ctrl_hash_feeder
  import rom_ctrl_pkg::*;
#(
  parameter  int RomDepth    = 16,
  parameter  int RomTopCount = 2,
  parameter  int DataWidth   = 40,
  localparam int AW          = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DataWidth-1:0]     rom_data_i,
  input  logic [AW-1:0]            data_addr_i,
  input  logic                     data_vld_i,
  input  logic                     data_last_nontop_i,
  output logic                     data_rdy_o,
  output logic                     kmac_valid_o,
  output logic [63:0]              kmac_data_o,
  output logic [7:0]               kmac_strb_o,
  output logic                     kmac_last_o,
  input  logic                     kmac_ready_i,
  output logic [32*RomTopCount-1:0] exp_digest_o,
  output logic                     exp_digest_vld_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int         NonTop  = RomDepth - RomTopCount;
  localparam logic [7:0] StrbVal = strb_mask(DataWidth);

  state_e                   r_state, w_state_nxt;
  logic [AW-1:0]            r_exp_addr;
  logic [32*RomTopCount-1:0] r_digest;
  logic                     w_rdy, w_bad, w_load, w_flush, w_inc, w_store;
  logic                     w_oreg_free;
  kmac_req_t                w_req;

  assign w_bad = (data_addr_i != r_exp_addr) ||
                 (data_last_nontop_i != (data_addr_i == AW'(NonTop - 1)));

  // The accept condition is formed per state from data_vld_i and the local
  // ready term so that data_rdy_o never feeds back into this block.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    w_inc       = 1'b0;
    w_store     = 1'b0;
    case (r_state)
      StHash: begin
        w_rdy = w_oreg_free;
        if (data_vld_i && w_oreg_free) begin
          if (w_bad) begin
            w_state_nxt = StError;
            w_flush     = 1'b1;
          end else begin
            w_load = 1'b1;
            w_inc  = 1'b1;
            if (data_last_nontop_i) w_state_nxt = StFlush;
          end
        end
      end
      StFlush: begin
        if (w_req.valid && kmac_ready_i && w_req.last) w_state_nxt = StTop;
      end
      StTop: begin
        w_rdy = 1'b1;
        if (data_vld_i) begin
          if (w_bad) begin
            w_state_nxt = StError;
          end else begin
            w_store = 1'b1;
            if (data_addr_i == AW'(RomDepth - 1)) w_state_nxt = StDone;
            else                                  w_inc       = 1'b1;
          end
        end
      end
      StDone, StError: begin
      end
      default: begin
        w_state_nxt = StError;
        w_flush     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StHash;
      r_exp_addr <= '0;
      r_digest   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_inc) r_exp_addr <= r_exp_addr + AW'(1);
      for (int unsigned i = 0; i < RomTopCount; i++) begin
        if (w_store && (data_addr_i == AW'(NonTop + i))) begin
          r_digest[32*i +: 32] <= rom_data_i[31:0];
        end
      end
    end
  end

  rom_ctrl_hash_feeder_oreg u_oreg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_data     (64'(rom_data_i)),
    .i_strb     (StrbVal),
    .i_last     (data_last_nontop_i),
    .i_ready    (kmac_ready_i),
    .o_req      (w_req),
    .o_can_load (w_oreg_free)
  );

  assign data_rdy_o       = w_rdy && !rst_i;
  assign kmac_valid_o     = w_req.valid;
  assign kmac_data_o      = w_req.data;
  assign kmac_strb_o      = w_req.strb;
  assign kmac_last_o      = w_req.last;
  assign exp_digest_o     = r_digest;
  assign done_o           = (r_state == StDone);
  assign exp_digest_vld_o = (r_state == StDone);
  assign err_o            = (r_state == StError);

endmodule
